i2c_reg_target: RTL and testbench

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

---
 rtl/i2c_reg_target.sv | 238 +++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// I2C register-access target: pointer write, data write with auto-increment, and sequential read.
// Define I2C_TARGET_FILTER_EN to add a FilterDepth-sample glitch filter behind the synchronisers.
module i2c_reg_target #(
    parameter logic [6:0] I2CAddress  = 7'h55,
    parameter int         FilterDepth = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

`ifdef I2C_TARGET_FILTER_EN
    localparam bit FilterEn = 1'b1;
`else
    localparam bit FilterEn = 1'b0;
`endif

    localparam int CntW         = (FilterDepth > 1) ? $clog2(FilterDepth) : 1;
    localparam int SettleCycles = FilterDepth + 4;
    localparam int SetW         = $clog2(SettleCycles + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Index 1 carries SCL, index 0 carries SDA through the input path.
    logic [1:0]      sync1, sync2, filt, bus_lvl;
    logic [CntW-1:0] filt_cnt [2];
    logic            scl, sda, scl_d, sda_d;
    logic            scl_rise, scl_fall, start_det, stop_det;
    logic [SetW-1:0] settle;
    logic            bus_ready;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       rw_bit;
    logic [1:0] ack_phase;
    logic [1:0] rd_wait;

    assign sda_o = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {scl_i, sda_i};
            sync2 <= sync1;
        end
    end

    // A line takes a new value only after FilterDepth consecutive samples disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= 2'b11;
            for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == CntW'(FilterDepth - 1)) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus_lvl = FilterEn ? filt : sync2;
    assign scl     = bus_lvl[1];
    assign sda     = bus_lvl[0];

    // The reset values of the input pipeline can fake a START when the bus is mid-transfer,
    // so condition detection waits until the pipeline holds only real samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
            settle <= '0;
        end else begin
            scl_d <= scl;
            sda_d <= sda;
            if (!bus_ready) settle <= settle + 1'b1;
        end
    end

    assign bus_ready = (settle == SetW'(SettleCycles));
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = bus_ready & scl & scl_d & sda_d & ~sda;
    assign stop_det  = bus_ready & scl & scl_d & ~sda_d & sda;

    // ACK states use ack_phase: 0 = waiting for the 8th-clock fall, 1 = waiting for the 9th-clock fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw_bit    <= 1'b0;
            ack_phase <= '0;
            rd_wait   <= '0;
            sda_t     <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            if (stop_det) begin
                state   <= IDLE;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                rd_wait <= '0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_t   <= 1'b1;
                rd_wait <= '0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt   <= '0;
                            rw_bit    <= sda;
                            ack_phase <= '0;
                            busy      <= (shreg == I2CAddress);
                            state     <= (shreg == I2CAddress) ? ADDR_ACK : IGNORE;
                        end else begin
                            shreg   <= {shreg[5:0], sda};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (ack_phase == 2'd0) begin
                            sda_t     <= 1'b0;
                            ack_phase <= 2'd1;
                        end else begin
                            sda_t     <= 1'b1;
                            ack_phase <= 2'd0;
                            bit_cnt   <= '0;
                            if (rw_bit) begin
                                reg_rd  <= 1'b1;
                                rd_wait <= 2'd2;
                                state   <= RDATA;
                            end else begin
                                state <= PTR;
                            end
                        end
                    end
                    PTR, WDATA: if (scl_rise) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt   <= '0;
                            ack_phase <= '0;
                            if (state == PTR) begin
                                reg_addr <= {shreg, sda};
                                state    <= PTR_ACK;
                            end else begin
                                reg_wdata <= {shreg, sda};
                                reg_wr    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end else begin
                            shreg   <= {shreg[5:0], sda};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (ack_phase == 2'd0) begin
                            sda_t     <= 1'b0;
                            ack_phase <= 2'd1;
                        end else begin
                            sda_t     <= 1'b1;
                            ack_phase <= 2'd0;
                            state     <= WDATA;
                            if (state == WDATA_ACK) reg_addr <= reg_addr + 8'd1;
                        end
                    end
                    RDATA: begin
                        if (rd_wait != 2'd0) begin
                            rd_wait <= rd_wait - 2'd1;
                            if (rd_wait == 2'd1) begin
                                shreg <= reg_rdata[6:0];
                                sda_t <= reg_rdata[7];
                            end
                        end else if (scl_rise) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt   <= '0;
                                ack_phase <= '0;
                                state     <= RDATA_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (scl_fall) begin
                            sda_t <= shreg[6];
                            shreg <= {shreg[5:0], 1'b0};
                        end
                    end
                    RDATA_ACK: begin
                        if (ack_phase == 2'd0 && scl_fall) begin
                            sda_t     <= 1'b1;
                            ack_phase <= 2'd1;
                        end else if (ack_phase == 2'd1 && scl_rise) begin
                            if (sda) begin
                                state <= IGNORE;
                            end else begin
                                reg_addr  <= reg_addr + 8'd1;
                                ack_phase <= 2'd2;
                            end
                        end else if (ack_phase == 2'd2 && scl_fall) begin
                            reg_rd    <= 1'b1;
                            rd_wait   <= 2'd2;
                            bit_cnt   <= '0;
                            ack_phase <= '0;
                            state     <= RDATA;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Self-checking bench for i2c_reg_target: a bit-level I2C controller model, a register-file
// model answering reg_rd, and logs of every reg_wr / reg_rd strobe.
module tb_i2c_reg_target;

    localparam int Q = 16;

    typedef struct {
        logic [6:0] dev;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
    } wr_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_ctrl, sda_ctrl;
    logic       sda_line;
    logic       sda_o, sda_t;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd, busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    logic       busy_seen;

    assign sda_line = sda_ctrl & (sda_t ? 1'b1 : sda_o);

    always #5 clk = ~clk;

    i2c_reg_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_ctrl),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register file answers one edge after reg_rd, so data is ready by the second edge.
    always @(posedge clk) if (reg_rd === 1'b1) reg_rdata <= mem[reg_addr];

    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (reg_rd === 1'b1) rd_addr_q.push_back(reg_addr);
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] wr_addr_at(input int i);
        return (i < wr_addr_q.size()) ? {8'h00, wr_addr_q[i]} : 16'hFFFF;
    endfunction

    function automatic logic [15:0] wr_data_at(input int i);
        return (i < wr_data_q.size()) ? {8'h00, wr_data_q[i]} : 16'hFFFF;
    endfunction

    function automatic logic [15:0] rd_addr_at(input int i);
        return (i < rd_addr_q.size()) ? {8'h00, rd_addr_q[i]} : 16'hFFFF;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        busy_seen = 1'b0;
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1; wait_q();
        scl_ctrl = 1'b1; wait_q();
        sda_ctrl = 1'b0; wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; wait_q();
        scl_ctrl = 1'b1; wait_q();
        sda_ctrl = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_ctrl = b;    wait_q();
        scl_ctrl = 1'b1; wait_q(); wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    // One-clock SDA pulse against the data value while SCL is high.
    task automatic send_glitch_bit(input logic b);
        sda_ctrl = b;    wait_q();
        scl_ctrl = 1'b1; wait_q();
        sda_ctrl = ~b;   @(negedge clk);
        sda_ctrl = b;    wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    task automatic ack_clock(output logic ack);
        sda_ctrl = 1'b1; wait_q();
        scl_ctrl = 1'b1; wait_q();
        ack = (sda_line === 1'b0);
        wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_clock(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] data);
        for (int i = 7; i >= 0; i--) begin
            sda_ctrl = 1'b1; wait_q();
            scl_ctrl = 1'b1; wait_q();
            data[i] = sda_line;
            wait_q();
            scl_ctrl = 1'b0; wait_q();
        end
        sda_ctrl = nack; wait_q();
        scl_ctrl = 1'b1; wait_q(); wait_q();
        scl_ctrl = 1'b0;
        repeat (2) @(negedge clk);
        sda_ctrl = 1'b1;
        repeat (Q - 2) @(negedge clk);
    endtask

    task automatic applyStimulus(input wr_vec_t v);
        logic a0, a1, a2;
        clear_log();
        i2c_start();
        write_byte({v.dev, 1'b0}, a0);
        write_byte(v.ptr, a1);
        write_byte(v.data, a2);
        i2c_stop();
        wait_q();
        checkOutput("addr_ack", a0, v.exp_ack);
        checkOutput("ptr_ack", a1, v.exp_ack);
        checkOutput("data_ack", a2, v.exp_ack);
        checkOutput("wr_count", 16'(wr_addr_q.size()), v.exp_ack ? 16'd1 : 16'd0);
        if (v.exp_ack) begin
            checkOutput("wr_addr", wr_addr_at(0), {8'h00, v.ptr});
            checkOutput("wr_data", wr_data_at(0), {8'h00, v.data});
        end
        checkOutput("rd_count", 16'(rd_addr_q.size()), 16'd0);
        checkOutput("busy_seen", busy_seen, v.exp_ack);
        checkOutput("busy_after_stop", busy, 1'b0);
        checkOutput("sda_released", sda_t, 1'b1);
    endtask

    initial begin
        wr_vec_t    vecs [5];
        logic       a0, a1, a2, a3, a4;
        logic [7:0] d0, d1;

        vecs[0] = '{7'h55, 8'h87, 8'h01, 1'b1};
        vecs[1] = '{7'h56, 8'h12, 8'h34, 1'b0};
        vecs[2] = '{7'h55, 8'h3C, 8'hC3, 1'b1};
        vecs[3] = '{7'h2A, 8'h00, 8'hFF, 1'b0};
        vecs[4] = '{7'h55, 8'hFF, 8'h5A, 1'b1};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[7]    = 8'hA5;
        mem[8]    = 8'h3C;
        reg_rdata = 8'h00;
        reset     = 1'b1;
        scl_ctrl  = 1'b1;
        sda_ctrl  = 1'b1;
        clear_log();

        repeat (4) @(negedge clk);
        checkOutput("rst_sda_t", sda_t, 1'b1);
        checkOutput("rst_sda_o", sda_o, 1'b0);
        checkOutput("rst_reg_addr", reg_addr, 16'h0000);
        checkOutput("rst_reg_wdata", reg_wdata, 16'h0000);
        checkOutput("rst_reg_wr", reg_wr, 1'b0);
        checkOutput("rst_reg_rd", reg_rd, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Pointer write, repeated START, single read ended by NACK.
        clear_log();
        i2c_start();
        write_byte(8'hAA, a0);
        write_byte(8'h07, a1);
        i2c_start();
        write_byte(8'hAB, a2);
        read_byte(1'b1, d0);
        checkOutput("rd_acks", {13'd0, a0, a1, a2}, 16'h0007);
        checkOutput("rd_data", d0, 16'h00A5);
        checkOutput("rd_release_after_nack", sda_t, 1'b1);
        i2c_stop();
        wait_q();
        checkOutput("rd_count", 16'(rd_addr_q.size()), 16'd1);
        checkOutput("rd_addr", rd_addr_at(0), 16'h0007);
        checkOutput("rd_no_wr", 16'(wr_addr_q.size()), 16'd0);
        checkOutput("rd_busy_after_stop", busy, 1'b0);

        // Pointer persists; ACKed read advances to the next register.
        clear_log();
        i2c_start();
        write_byte(8'hAB, a0);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        wait_q();
        checkOutput("seq_addr_ack", a0, 1'b1);
        checkOutput("seq_data0", d0, 16'h00A5);
        checkOutput("seq_data1", d1, 16'h003C);
        checkOutput("seq_rd_count", 16'(rd_addr_q.size()), 16'd2);
        checkOutput("seq_rd_addr0", rd_addr_at(0), 16'h0007);
        checkOutput("seq_rd_addr1", rd_addr_at(1), 16'h0008);

        // Pointer wraps from 0xFF to 0x00.
        clear_log();
        i2c_start();
        write_byte(8'hAA, a0);
        write_byte(8'hFE, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        write_byte(8'h33, a4);
        i2c_stop();
        wait_q();
        checkOutput("wrap_acks", {11'd0, a0, a1, a2, a3, a4}, 16'h001F);
        checkOutput("wrap_wr_count", 16'(wr_addr_q.size()), 16'd3);
        checkOutput("wrap_addr0", wr_addr_at(0), 16'h00FE);
        checkOutput("wrap_data0", wr_data_at(0), 16'h0011);
        checkOutput("wrap_addr1", wr_addr_at(1), 16'h00FF);
        checkOutput("wrap_data1", wr_data_at(1), 16'h0022);
        checkOutput("wrap_addr2", wr_addr_at(2), 16'h0000);
        checkOutput("wrap_data2", wr_data_at(2), 16'h0033);
        checkOutput("wrap_final_ptr", reg_addr, 16'h0001);

        // STOP after four data bits discards the partial byte.
        clear_log();
        i2c_start();
        write_byte(8'hAA, a0);
        write_byte(8'h40, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        wait_q();
        checkOutput("partial_acks", {14'd0, a0, a1}, 16'h0003);
        checkOutput("partial_no_wr", 16'(wr_addr_q.size()), 16'd0);

        // Reset while the target is driving the pointer ACK.
        clear_log();
        i2c_start();
        write_byte(8'hAA, a0);
        for (int i = 7; i >= 0; i--) send_bit(i[0]);
        sda_ctrl = 1'b1; wait_q();
        scl_ctrl = 1'b1; wait_q();
        checkOutput("ack_driven_before_reset", sda_line, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("reset_async_release", sda_t, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_clears_ptr", reg_addr, 16'h0000);
        checkOutput("reset_clears_busy", busy, 1'b0);
        wait_q();
        scl_ctrl = 1'b0; wait_q();
        busy_seen = 1'b0;
        write_byte(8'hAA, a1);
        i2c_stop();
        wait_q();
        checkOutput("ignore_until_start_ack", a1, 1'b0);
        checkOutput("ignore_until_start_busy", busy_seen, 1'b0);
        checkOutput("reset_seq_no_wr", 16'(wr_addr_q.size()), 16'd0);
        checkOutput("reset_seq_no_rd", 16'(rd_addr_q.size()), 16'd0);

`ifdef I2C_TARGET_FILTER_EN
        // Single-clock SDA pulses while SCL is high must not look like START or STOP.
        clear_log();
        i2c_start();
        write_byte(8'hAA, a0);
        write_byte(8'h20, a1);
        send_glitch_bit(1'b1);
        send_glitch_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        ack_clock(a2);
        i2c_stop();
        wait_q();
        checkOutput("glitch_acks", {13'd0, a0, a1, a2}, 16'h0007);
        checkOutput("glitch_wr_count", 16'(wr_addr_q.size()), 16'd1);
        checkOutput("glitch_wr_addr", wr_addr_at(0), 16'h0020);
        checkOutput("glitch_wr_data", wr_data_at(0), 16'h0096);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
